// File: rtl/axil_rr_master_arb.sv
// rtl/axil_rr_master_arb.sv - two-requester round-robin front end onto one AXI4-Lite master port
`timescale 1ns/1ps

module axil_rr_master_arb #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,

    input  logic                          req0_valid,
    input  logic                          req0_we,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] req0_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] req0_wdata,
    output logic                          req0_ready,
    output logic                          req0_done,
    output logic [C_M_AXI_DATA_WIDTH-1:0] req0_rdata,
    output logic [1:0]                    req0_resp,

    input  logic                          req1_valid,
    input  logic                          req1_we,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] req1_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] req1_wdata,
    output logic                          req1_ready,
    output logic                          req1_done,
    output logic [C_M_AXI_DATA_WIDTH-1:0] req1_rdata,
    output logic [1:0]                    req1_resp,

    output logic [C_M_AXI_ADDR_WIDTH-1:0] AWADDR,
    output logic [2:0]                    AWPROT,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] WDATA,
    output logic [3:0]                    WSTRB,
    output logic                          WVALID,
    input  logic                          WREADY,
    input  logic [1:0]                    BRESP,
    input  logic                          BVALID,
    output logic                          BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic [2:0]                    ARPROT,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RVALID,
    output logic                          RREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_AW_W, S_WR_B, S_RD_AR, S_RD_R, S_DONE
    } state_t;

    state_t                        r_state;
    logic                          r_last_grant;
    logic                          r_grant;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;
    logic                          r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                          r_done0, r_done1;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_rdata0, r_rdata1;
    logic [1:0]                    r_resp0, r_resp1;

    logic                          w_any;
    logic                          w_grant;
    logic                          w_accept;
    logic                          w_sel_we;
    logic [C_M_AXI_ADDR_WIDTH-1:0] w_sel_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] w_sel_wdata;
    logic                          w_aw_ok, w_w_ok;

    // On a tie the requester not served last wins; a lone requester always wins.
    assign w_any       = req0_valid | req1_valid;
    assign w_grant     = req0_valid ? (req1_valid ? ~r_last_grant : 1'b0) : 1'b1;
    assign w_accept    = ARESETN && (r_state == S_IDLE) && w_any;
    assign w_sel_we    = w_grant ? req1_we    : req0_we;
    assign w_sel_addr  = w_grant ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant ? req1_wdata : req0_wdata;

    // A write channel counts as finished once its valid has dropped or is handshaking now.
    assign w_aw_ok = !r_awvalid || AWREADY;
    assign w_w_ok  = !r_wvalid  || WREADY;

    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept &&  w_grant;
    assign req0_done  = r_done0;
    assign req1_done  = r_done1;
    assign req0_rdata = r_rdata0;
    assign req1_rdata = r_rdata1;
    assign req0_resp  = r_resp0;
    assign req1_resp  = r_resp1;

    assign AWADDR  = r_addr;
    assign AWPROT  = 3'b000;
    assign AWVALID = r_awvalid;
    assign WDATA   = r_wdata;
    assign WSTRB   = 4'hF;
    assign WVALID  = r_wvalid;
    assign BREADY  = r_bready;
    assign ARADDR  = r_addr;
    assign ARPROT  = 3'b000;
    assign ARVALID = r_arvalid;
    assign RREADY  = r_rready;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_resp0      <= 2'b00;
            r_resp1      <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        if (w_sel_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_AW_W;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_AR;
                        end
                    end
                end
                S_WR_AW_W: begin
                    if (AWREADY) r_awvalid <= 1'b0;
                    if (WREADY)  r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (BVALID) begin
                        r_bready <= 1'b0;
                        if (r_grant) r_resp1 <= BRESP;
                        else         r_resp0 <= BRESP;
                        r_done0  <= !r_grant;
                        r_done1  <= r_grant;
                        r_state  <= S_DONE;
                    end
                end
                S_RD_AR: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (RVALID) begin
                        r_rready <= 1'b0;
                        if (r_grant) begin
                            r_rdata1 <= RDATA;
                            r_resp1  <= RRESP;
                        end else begin
                            r_rdata0 <= RDATA;
                            r_resp0  <= RRESP;
                        end
                        r_done0  <= !r_grant;
                        r_done1  <= r_grant;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_rr_master_arb.sv
// tb/tb_axil_rr_master_arb.sv - directed scoreboard bench for axil_rr_master_arb with a delay-programmable AXI-Lite slave
`timescale 1ns/1ps

module tb_axil_rr_master_arb;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic        req0_ready, req0_done, req1_ready, req1_done;
    logic [31:0] req0_rdata, req1_rdata;
    logic [1:0]  req0_resp, req1_resp;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    axil_rr_master_arb #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_resp(req0_resp),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_resp(req1_resp),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Slave model: per-channel ready/response delays, word memory, SLVERR on writes to 0x10.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0;
    int          aw_wait = 0, w_wait = 0, b_wait = 0, r_wait = 0;
    logic        s_got_aw = 1'b0, s_got_w = 1'b0, s_b_pend = 1'b0, s_r_pend = 1'b0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_rdata = '0;
    logic [31:0] s_mem [logic [31:0]];
    int          n_aw = 0, n_w = 0, hs_cyc = 0;

    assign AWREADY = AWVALID && (aw_wait >= aw_dly);
    assign WREADY  = WVALID  && (w_wait  >= w_dly);
    assign ARREADY = ARVALID;
    assign BVALID  = s_b_pend && (b_wait >= b_dly);
    assign BRESP   = (s_awaddr == 32'h10) ? 2'b10 : 2'b00;
    assign RVALID  = s_r_pend && (r_wait >= r_dly);
    assign RDATA   = s_rdata;
    assign RRESP   = 2'b00;

    always @(posedge ACLK) begin : slave
        logic        ga, gw;
        logic [31:0] wa, wd;
        if (!ARESETN) begin
            s_got_aw <= 1'b0; s_got_w <= 1'b0; s_b_pend <= 1'b0; s_r_pend <= 1'b0;
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; r_wait <= 0;
        end else begin
            aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
            w_wait  <= (WVALID  && !WREADY)  ? w_wait + 1  : 0;
            ga = s_got_aw || (AWVALID && AWREADY);
            gw = s_got_w  || (WVALID && WREADY);
            wa = (AWVALID && AWREADY) ? AWADDR : s_awaddr;
            wd = (WVALID && WREADY)   ? WDATA  : s_wdata;
            if (AWVALID && AWREADY) begin s_awaddr <= AWADDR; n_aw <= n_aw + 1; end
            if (WVALID && WREADY)   begin s_wdata  <= WDATA;  n_w  <= n_w + 1;  end
            if (ga && gw) begin
                s_mem[wa] = wd;
                s_b_pend <= 1'b1; b_wait <= 0;
                s_got_aw <= 1'b0; s_got_w <= 1'b0;
            end else begin
                s_got_aw <= ga; s_got_w <= gw;
            end
            if (s_b_pend) begin
                if (BVALID && BREADY) begin s_b_pend <= 1'b0; hs_cyc <= cyc; end
                else if (!BVALID) b_wait <= b_wait + 1;
            end
            if (ARVALID && ARREADY) begin
                s_rdata  <= s_mem.exists(ARADDR) ? s_mem[ARADDR] : 32'h0;
                s_r_pend <= 1'b1; r_wait <= 0;
            end
            if (s_r_pend) begin
                if (RVALID && RREADY) begin s_r_pend <= 1'b0; hs_cyc <= cyc; end
                else if (!RVALID) r_wait <= r_wait + 1;
            end
        end
    end

    typedef struct {
        int          id;
        bit          we;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          acc;
        int          lat;
        int          aw_base;
        int          w_base;
    } sb_t;
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
    } cmd_t;

    sb_t         sb[$];
    cmd_t        cq0[$], cq1[$];
    logic [31:0] m_mem [logic [31:0]];
    logic [31:0] m_last_rd [2];
    bit          m_last = 1'b1;

    // Completion monitor: pops the scoreboard on every done pulse.
    always @(negedge ACLK) begin : monitor
        sb_t         e;
        logic        d;
        logic [31:0] rd;
        logic [1:0]  rs;
        if (ARESETN) begin
            if (s_b_pend && !BVALID) begin
                checks++;
                assert (BREADY === 1'b1) else begin errors++; $error("FAIL bready_hold: got %b exp 1", BREADY); end
            end
            if (s_r_pend && !RVALID) begin
                checks++;
                assert (RREADY === 1'b1) else begin errors++; $error("FAIL rready_hold: got %b exp 1", RREADY); end
            end
            if (AWVALID || ARVALID) begin
                checks++;
                assert ({AWPROT, ARPROT, WSTRB} === 10'h00F) else begin
                    errors++; $error("FAIL prot_strb: got %h exp 00f", {AWPROT, ARPROT, WSTRB}); end
            end
        end
        for (int n = 0; n < 2; n++) begin
            d  = (n == 1) ? req1_done  : req0_done;
            rd = (n == 1) ? req1_rdata : req0_rdata;
            rs = (n == 1) ? req1_resp  : req0_resp;
            if (d) begin
                checks++;
                assert (sb.size() > 0) else begin errors++; $error("FAIL unexpected_done: req%0d done, exp no done", n); end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    assert (n === e.id && rd === e.rdata && rs === e.resp) else begin
                        errors++;
                        $error("FAIL done_data: got req%0d rdata=%h resp=%b exp req%0d rdata=%h resp=%b",
                               n, rd, rs, e.id, e.rdata, e.resp);
                    end
                    checks++;
                    assert (cyc === hs_cyc + 1) else begin
                        errors++; $error("FAIL done_timing: got cycle %0d exp %0d", cyc, hs_cyc + 1); end
                    if (e.lat != 0) begin
                        checks++;
                        assert (cyc - e.acc === e.lat) else begin
                            errors++; $error("FAIL latency: got %0d exp %0d", cyc - e.acc, e.lat); end
                    end
                    if (e.we) begin
                        checks++;
                        assert (n_aw - e.aw_base === 1 && n_w - e.w_base === 1) else begin
                            errors++; $error("FAIL hs_count: got aw=%0d w=%0d exp 1 1", n_aw - e.aw_base, n_w - e.w_base); end
                    end
                end
            end
        end
    end

    task automatic push_cmd(input int id, input bit we, input logic [31:0] addr,
                            input logic [31:0] data, input int lat);
        cmd_t c;
        c.we = we; c.addr = addr; c.data = data; c.lat = lat;
        if (id == 1) cq1.push_back(c);
        else         cq0.push_back(c);
    endtask

    task automatic run_cmds(input int budget);
        int   left;
        bit   g_exp, g_act;
        cmd_t c;
        sb_t  e;
        left = budget;
        @(negedge ACLK);
        while ((cq0.size() > 0 || cq1.size() > 0) && left > 0) begin
            req0_valid = (cq0.size() > 0);
            req1_valid = (cq1.size() > 0);
            if (req0_valid) begin req0_we = cq0[0].we; req0_addr = cq0[0].addr; req0_wdata = cq0[0].data; end
            if (req1_valid) begin req1_we = cq1[0].we; req1_addr = cq1[0].addr; req1_wdata = cq1[0].data; end
            #1;
            if (req0_ready || req1_ready) begin
                g_exp = (req0_valid && req1_valid) ? !m_last : req1_valid;
                g_act = req1_ready;
                checks++;
                assert (g_act === g_exp && !(req0_ready && req1_ready)) else begin
                    errors++; $error("FAIL grant: got req%0d (both=%b) exp req%0d", g_act, req0_ready && req1_ready, g_exp); end
                m_last = g_act;
                c = g_act ? cq1.pop_front() : cq0.pop_front();
                e.id = int'(g_act); e.we = c.we; e.acc = cyc; e.lat = c.lat;
                e.aw_base = n_aw; e.w_base = n_w;
                if (c.we) begin
                    m_mem[c.addr] = c.data;
                    e.rdata = m_last_rd[g_act];
                    e.resp  = (c.addr == 32'h10) ? 2'b10 : 2'b00;
                end else begin
                    e.rdata = m_mem.exists(c.addr) ? m_mem[c.addr] : 32'h0;
                    m_last_rd[g_act] = e.rdata;
                    e.resp  = 2'b00;
                end
                sb.push_back(e);
            end
            @(negedge ACLK);
            left--;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        while (sb.size() > 0 && left > 0) begin
            @(negedge ACLK);
            left--;
        end
        checks++;
        assert (left > 0) else begin
            errors++; $error("FAIL timeout: got %0d pending exp 0", sb.size() + cq0.size() + cq1.size()); end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        assert ({AWVALID, WVALID, BREADY, ARVALID, RREADY, req0_ready, req1_ready, req0_done, req1_done} === 9'b0)
        else begin errors++; $error("FAIL %s_ctrl: got %b exp 0", tag,
            {AWVALID, WVALID, BREADY, ARVALID, RREADY, req0_ready, req1_ready, req0_done, req1_done}); end
        checks++;
        assert ({req0_rdata, req1_rdata, req0_resp, req1_resp} === 68'b0)
        else begin errors++; $error("FAIL %s_rsp: got %h %h %b %b exp 0", tag, req0_rdata, req1_rdata, req0_resp, req1_resp); end
        checks++;
        assert ({AWADDR, ARADDR, WDATA} === 96'b0)
        else begin errors++; $error("FAIL %s_cmd: got %h %h %h exp 0", tag, AWADDR, ARADDR, WDATA); end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_last_rd[0] = '0;
        m_last_rd[1] = '0;
        sb.delete();
    endtask

    initial begin
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        model_reset();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_idle("reset");
        ARESETN = 1'b1;

        // First tie after reset, then continuous contention: grants 0,1,0,1.
        push_cmd(0, 1, 32'h100, 32'hA0, 3); push_cmd(0, 1, 32'h104, 32'hA1, 3);
        push_cmd(1, 1, 32'h200, 32'hB0, 3); push_cmd(1, 1, 32'h204, 32'hB1, 3);
        run_cmds(200);

        for (int i = 0; i < 4; i++) push_cmd(0, 1, 32'(4 * i), 32'(i + 1), 3);
        for (int i = 0; i < 4; i++) push_cmd(0, 0, 32'(4 * i), 32'h0, 3);
        run_cmds(300);

        aw_dly = 0; w_dly = 3; push_cmd(0, 1, 32'h30, 32'h5555_0001, 0); run_cmds(100);
        aw_dly = 3; w_dly = 0; push_cmd(0, 1, 32'h34, 32'h5555_0002, 0); run_cmds(100);
        aw_dly = 2; w_dly = 2; push_cmd(0, 1, 32'h38, 32'h5555_0003, 0); run_cmds(100);
        aw_dly = 0; w_dly = 0;
        push_cmd(1, 0, 32'h30, 32'h0, 3); push_cmd(1, 0, 32'h34, 32'h0, 3); push_cmd(1, 0, 32'h38, 32'h0, 3);
        run_cmds(200);

        b_dly = 5; r_dly = 7;
        push_cmd(0, 1, 32'h40, 32'hDEAD_BEEF, 0); push_cmd(0, 0, 32'h40, 32'h0, 0);
        run_cmds(200);
        b_dly = 0; r_dly = 0;

        push_cmd(1, 1, 32'h10, 32'h0000_0077, 3);
        run_cmds(100);

        // Reset while the write waits in WR_B: the write must vanish without a done.
        b_dly = 5;
        @(negedge ACLK);
        req0_valid = 1; req0_we = 1; req0_addr = 32'h50; req0_wdata = 32'h1234_5678;
        #1;
        checks++;
        assert (req0_ready === 1'b1) else begin errors++; $error("FAIL rst_accept: got %b exp 1", req0_ready); end
        @(negedge ACLK);
        req0_valid = 0;
        @(negedge ACLK);
        checks++;
        assert (BREADY === 1'b1) else begin errors++; $error("FAIL rst_in_wrb: got %b exp 1", BREADY); end
        ARESETN = 1'b0;
        @(negedge ACLK);
        check_idle("midreset");
        model_reset();
        @(negedge ACLK);
        ARESETN = 1'b1;
        b_dly = 0;
        repeat (4) @(negedge ACLK);
        push_cmd(1, 0, 32'h4, 32'h0, 3);
        push_cmd(0, 0, 32'h8, 32'h0, 3);
        run_cmds(100);

        repeat (3) @(negedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
